// File: rtl/line_fetch_engine.sv
// line_fetch_engine: miss-fill stage behind the LRU cache way.
// Turns one line tag into one AXI4 INCR read burst covering the whole line.
// The burst beats come back through a 2-entry output buffer, in order.
// Malformed responses are counted but never stall the fill: a line always
// terminates on the beat count, not on rlast.
module line_fetch_engine #(
    parameter int TAGS_WIDTH     = 48,
    parameter int CACHE_SIZE     = 512,
    parameter int DATA_PORT_SIZE = 512,
    parameter int AXI_ADDR_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    // tag request stream from the cache way
    input  logic                      s_addr_tvalid,
    output logic                      s_addr_tready,
    input  logic [TAGS_WIDTH-1:0]     s_addr_tdata,
    // line beat stream back to the cache way
    output logic                      m_data_tvalid,
    input  logic                      m_data_tready,
    output logic [DATA_PORT_SIZE-1:0] m_data_tdata,
    output logic                      m_data_tlast,
    // AXI4 read address channel
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    // AXI4 read data channel
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [DATA_PORT_SIZE-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    // status
    output logic                      busy,
    output logic [15:0]               err_cnt
);

    localparam int BEATS  = CACHE_SIZE / DATA_PORT_SIZE;
    localparam int LSB    = $clog2(CACHE_SIZE / 8);
    localparam int FULL_W = TAGS_WIDTH + LSB;
    localparam int WIDE_W = (FULL_W > AXI_ADDR_WIDTH) ? FULL_W : AXI_ADDR_WIDTH;

    localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_R    = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic [15:0]               err_cnt_q, err_cnt_d;

    // output buffer bookkeeping
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic [DATA_PORT_SIZE-1:0] entry_data [2];
    logic                      entry_last [2];

    logic [WIDE_W-1:0] tag_addr_wide;
    logic              r_fire;
    logic              push;
    logic              pop;
    logic              at_last;
    logic              err_event;

    // Line byte address: tag shifted past the in-line offset, then fitted to
    // the AXI address width (zero-extended or truncated).
    assign tag_addr_wide = WIDE_W'(s_addr_tdata) << LSB;

    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = 3'($clog2(DATA_PORT_SIZE / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = (state_q == ST_AR);
    assign s_addr_tready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign err_cnt       = err_cnt_q;

    // rready: always sink in IDLE (strays), never in AR, buffer space in R.
    always_comb begin
        m_axi_rready = 1'b0;
        case (state_q)
            ST_IDLE: m_axi_rready = 1'b1;
            ST_R:    m_axi_rready = (count_q != 2'd2);
            default: m_axi_rready = 1'b0;
        endcase
    end

    assign r_fire    = m_axi_rvalid & m_axi_rready;
    assign push      = r_fire & (state_q == ST_R);
    assign pop       = m_data_tvalid & m_data_tready;
    assign at_last   = (beat_cnt_q == LAST_BEAT);
    // One increment per offending beat, however many faults it carries.
    assign err_event = r_fire & ((state_q == ST_IDLE) |
                                 ((state_q == ST_R) &
                                  ((m_axi_rresp != 2'b00) | (m_axi_rlast != at_last))));

    // Fetch sequencing, beat counting and error accounting.
    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        beat_cnt_d = beat_cnt_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s_addr_tvalid) begin
                    araddr_d = tag_addr_wide[AXI_ADDR_WIDTH-1:0];
                    state_d  = ST_AR;
                end
            end
            ST_AR: begin
                if (m_axi_arready) begin
                    beat_cnt_d = 8'd0;
                    state_d    = ST_R;
                end
            end
            ST_R: begin
                if (push) begin
                    if (at_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (err_event && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Buffer pointers and occupancy; a push is only possible with space left.
    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset also abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            araddr_q   <= '0;
            beat_cnt_q <= 8'd0;
            err_cnt_q  <= 16'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Buffer entries: each captures {rdata, tlast} when it is the write slot.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
        logic [DATA_PORT_SIZE-1:0] data_q, data_d;
        logic                      last_q, last_d;

        // Capture the beat when this slot is written.
        always_comb begin
            data_d = data_q;
            last_d = last_q;
            if (push && (wr_ptr_q == 1'(gi))) begin
                data_d = m_axi_rdata;
                last_d = at_last;
            end
        end

        // Entry storage, cleared on reset so the idle output reads zero.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                data_q <= '0;
                last_q <= 1'b0;
            end else begin
                data_q <= data_d;
                last_q <= last_d;
            end
        end

        assign entry_data[gi] = data_q;
        assign entry_last[gi] = last_q;
    end

    assign m_data_tvalid = (count_q != 2'd0);
    assign m_data_tdata  = entry_data[rd_ptr_q];
    assign m_data_tlast  = entry_last[rd_ptr_q];

endmodule
